// File: rtl/ex_stage_mc_pkg.sv
// Shared rv32i types for the execute stage: ALU/branch/RV32M operation encodings and
// the multi-cycle FSM state type.
package rv32i_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_ops;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } ex_mc_state_t;

    function automatic logic md_is_div(input md_funct3_t op);
        return op[2];
    endfunction

    function automatic logic md_a_signed(input md_funct3_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input md_funct3_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_stage_mc_muldiv.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with divide-by-zero and signed-overflow resolved at start.
module muldiv_iter
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  md_funct3_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            fin,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    ex_mc_state_t state, state_n;

    logic [2*XLEN-1:0] acc_p0, acc_step, prod;
    logic [XLEN-1:0]   opb_p0, a_mag, b_mag;
    logic [CNT_W-1:0]  cnt_p0;
    logic              quo_neg_p0, rem_neg_p0, sel_p0;
    logic              a_sgn, b_sgn, div_zero, div_ovf, last;
    logic [XLEN:0]     mul_sum, div_trial;

    function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [XLEN-1:0] div_special(input logic is_rem, input logic zero,
                                                     input logic [XLEN-1:0] dividend);
        if (zero)
            return is_rem ? dividend : {XLEN{1'b1}};
        return is_rem ? {XLEN{1'b0}} : dividend;
    endfunction

    always_comb begin
        a_sgn    = md_a_signed(op) && a[XLEN-1];
        b_sgn    = md_b_signed(op) && b[XLEN-1];
        a_mag    = a_sgn ? -a : a;
        b_mag    = b_sgn ? -b : b;
        div_zero = md_is_div(op) && (b == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == MIN_NEG) && (b == '1);
        last     = (cnt_p0 == CNT_W'(XLEN-1));
    end

    // acc_p0 holds {partial product high, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_p0[2*XLEN-1:XLEN]} + {1'b0, opb_p0 & {XLEN{acc_p0[0]}}};
        div_trial = {acc_p0[2*XLEN-1:XLEN], acc_p0[XLEN-1]} - {1'b0, opb_p0};
        if (state == DIV) begin
            if (!div_trial[XLEN])
                acc_step = {div_trial[XLEN-1:0], acc_p0[XLEN-2:0], 1'b1};
            else
                acc_step = {acc_p0[2*XLEN-2:XLEN], acc_p0[XLEN-1], acc_p0[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_p0[XLEN-1:1]};
        end
        prod = quo_neg_p0 ? -acc_step : acc_step;
    end

    always_comb begin
        state_n = state;
        fin     = 1'b0;
        result  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (div_zero || div_ovf) begin
                        state_n = DONE;
                        fin     = 1'b1;
                        result  = div_special(op[1], div_zero, a);
                    end else begin
                        state_n = md_is_div(op) ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                if (last) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    result  = sel_p0 ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                end
            end
            DIV: begin
                if (last) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    result  = sel_p0 ? fix_sign(acc_step[2*XLEN-1:XLEN], rem_neg_p0)
                                     : fix_sign(acc_step[XLEN-1:0], quo_neg_p0);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            fin     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // ---- p0: latched operands and iteration state ----
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc_p0     <= {{XLEN{1'b0}}, md_is_div(op) ? a_mag : b_mag};
            opb_p0     <= md_is_div(op) ? b_mag : a_mag;
            cnt_p0     <= '0;
            quo_neg_p0 <= a_sgn ^ b_sgn;
            rem_neg_p0 <= a_sgn;
            sel_p0     <= md_is_div(op) ? op[1] : (op != MD_MUL);
        end else if (state == MUL || state == DIV) begin
            acc_p0 <= acc_step;
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/ex_stage_mc.sv
// rv32i execute stage: forwarding, operand muxes, ALU/compare and iterative RV32M unit.
// Optional build macro EX_FAST_MUL_EN: single-cycle combinational multiplier for mul*.
module ex_stage_mc
    import rv32i_types::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    localparam int FSEL_W = $clog2(NUM_FWD+1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic                          in_is_md,
    input  alu_ops                        in_aluop,
    input  logic [2:0]                    in_mdop,
    input  branch_funct3_t                in_cmpop,
    input  logic                          in_op1_sel,
    input  logic                          in_op2_sel,
    input  logic                          in_cmp2_sel,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [XLEN-1:0]               in_rs1,
    input  logic [XLEN-1:0]               in_rs2,
    input  logic [XLEN-1:0]               in_imm,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
    input  logic [FSEL_W-1:0]             fwd_sel1,
    input  logic [FSEL_W-1:0]             fwd_sel2,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_result,
    output logic                          out_cmp,
    output logic                          busy
);

    logic [XLEN-1:0] rs1_f, rs2_f, op1, op2, cmp2, alu_res, md_res, res_p1;
    logic            cmp_res, cmp_p1, vld_p1;
    logic            accept, md_iter, md_start, alu_take, md_fin;
    md_funct3_t      mdop;

    function automatic logic [XLEN-1:0] fwd_pick(input logic [FSEL_W-1:0] sel,
                                                  input logic [XLEN-1:0] rf,
                                                  input logic [NUM_FWD-1:0][XLEN-1:0] src);
        logic [XLEN-1:0] v;
        v = (sel == '0) ? rf : '0;
        for (int k = 0; k < NUM_FWD; k++)
            if (sel == FSEL_W'(k+1))
                v = src[k];
        return v;
    endfunction

    function automatic logic [XLEN-1:0] alu_calc(input alu_ops op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic [$clog2(XLEN)-1:0] sh;
        sa = a;
        sb = b;
        sh = b[$clog2(XLEN)-1:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, sa < sb};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return sa >>> sh;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_LUI:  return b;
            default:  return '0;
        endcase
    endfunction

    function automatic logic cmp_calc(input branch_funct3_t op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLT:     return sa < sb;
            BGE:     return sa >= sb;
            BLTU:    return a < b;
            BGEU:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

`ifdef EX_FAST_MUL_EN
    function automatic logic [XLEN-1:0] fast_mul(input md_funct3_t op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN:0]     ea, eb;
        logic signed [2*XLEN+1:0] p;
        ea = {md_a_signed(op) & a[XLEN-1], a};
        eb = {md_b_signed(op) & b[XLEN-1], b};
        p  = ea * eb;
        return (op == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction
`endif

    always_comb begin
        mdop     = md_funct3_t'(in_mdop);
        rs1_f    = fwd_pick(fwd_sel1, in_rs1, fwd_data);
        rs2_f    = fwd_pick(fwd_sel2, in_rs2, fwd_data);
        op1      = in_op1_sel ? in_pc : rs1_f;
        op2      = in_op2_sel ? in_imm : rs2_f;
        cmp2     = in_cmp2_sel ? in_imm : rs2_f;
        cmp_res  = cmp_calc(in_cmpop, rs1_f, cmp2);
        accept   = in_valid && in_ready && !flush;
`ifdef EX_FAST_MUL_EN
        md_iter  = in_is_md && md_is_div(mdop);
        alu_res  = in_is_md ? fast_mul(mdop, rs1_f, rs2_f) : alu_calc(in_aluop, op1, op2);
`else
        md_iter  = in_is_md;
        alu_res  = alu_calc(in_aluop, op1, op2);
`endif
        md_start = accept && md_iter;
        alu_take = accept && !md_iter;
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .flush  (flush),
        .op     (mdop),
        .a      (rs1_f),
        .b      (rs2_f),
        .busy   (busy),
        .fin    (md_fin),
        .result (md_res)
    );

    // ---- p1: EX/MEM-facing result register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
            cmp_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (!flush) begin
                if (md_fin) begin
                    vld_p1 <= 1'b1;
                    res_p1 <= md_res;
                end else if (alu_take) begin
                    vld_p1 <= 1'b1;
                    res_p1 <= alu_res;
                    cmp_p1 <= cmp_res;
                end
            end
        end
    end

    assign in_ready   = !busy;
    assign out_valid  = vld_p1;
    assign out_result = res_p1;
    assign out_cmp    = cmp_p1;

endmodule
